// File: rtl/div_ctrl.sv
// Iterative restoring divider sequencer for the EX stage (DIV/DIVU/REM/REMU).
// Holds the pipeline via stallreq_o and presents quotient/remainder for one cycle with ready_o.
//
// state | meaning
// IDLE  | waiting for an accepted divide
// ON    | one restoring step per cycle, WIDTH cycles
// END   | results valid, ready_o pulses for one cycle
module div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] opv1,
  input  logic [WIDTH-1:0] opv2,
  input  logic             annul_i,
  output logic [WIDTH-1:0] quo_o,
  output logic [WIDTH-1:0] rem_o,
  output logic             ready_o,
  output logic             stallreq_o
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ON, END} state_t;

  state_t           r_state;
  state_t           w_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic             r_neg_q;
  logic             r_neg_r;

  logic             w_accept;
  logic             w_sign1;
  logic             w_sign2;
  logic [WIDTH-1:0] w_mag1;
  logic [WIDTH-1:0] w_mag2;
  logic             w_div0;
  logic             w_ovf;
  logic             w_last;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nx;
  logic [WIDTH-1:0] w_quo_nx;

  assign w_accept = (r_state == IDLE) && start_i && !annul_i;
  assign w_sign1  = signed_i & opv1[WIDTH-1];
  assign w_sign2  = signed_i & opv2[WIDTH-1];
  assign w_mag1   = w_sign1 ? -opv1 : opv1;
  assign w_mag2   = w_sign2 ? -opv2 : opv2;
  assign w_div0   = (opv2 == '0);
  assign w_ovf    = signed_i && (opv1 == {1'b1, {(WIDTH-1){1'b0}}}) && (&opv2);
  assign w_last   = (r_cnt == LAST);

  // The shifted partial remainder carries one extra bit so the compare cannot overflow.
  assign w_shift  = {r_rem, r_quo[WIDTH-1]};
  assign w_ge     = (w_shift >= {1'b0, r_dvs});
  assign w_rem_nx = w_ge ? (w_shift[WIDTH-1:0] - r_dvs) : w_shift[WIDTH-1:0];
  assign w_quo_nx = {r_quo[WIDTH-2:0], w_ge};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_nxt;
  end

  always_comb begin
    w_nxt      = r_state;
    stallreq_o = 1'b0;
    ready_o    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          stallreq_o = 1'b1;
          w_nxt      = (w_div0 || w_ovf) ? END : ON;
        end
      end
      ON: begin
        if (annul_i) begin
          w_nxt = IDLE;
        end else begin
          stallreq_o = 1'b1;
          if (w_last) w_nxt = END;
        end
      end
      END: begin
        ready_o = 1'b1;
        w_nxt   = IDLE;
      end
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      quo_o   <= '0;
      rem_o   <= '0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= w_mag1;
      r_dvs   <= w_mag2;
      r_neg_q <= w_sign1 ^ w_sign2;
      r_neg_r <= w_sign1;
      if (w_div0) begin
        quo_o <= '1;
        rem_o <= opv1;
      end else if (w_ovf) begin
        quo_o <= opv1;
        rem_o <= '0;
      end
    end else if (r_state == ON) begin
      if (annul_i) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
        r_rem <= w_rem_nx;
        r_quo <= w_quo_nx;
        // Outputs only change on completion so an annulled divide leaves them untouched.
        if (w_last) begin
          quo_o <= r_neg_q ? -w_quo_nx : w_quo_nx;
          rem_o <= r_neg_r ? -w_rem_nx : w_rem_nx;
        end
      end
    end
  end

endmodule
